ahblite_acc_pid: RTL and testbench



---
 rtl/ahblite_acc_pid_if.sv | 24 ++
 rtl/ahblite_acc_pid.sv | 151 +++++++++++++++
 tb/tb_ahblite_acc_pid.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahblite_acc_pid_if.sv
// AHB-Lite bus bundle for the PID accelerator responder (ahblite_acc_pid).
// master = bus initiator side, slave = responder side.
interface ahblite_acc_pid_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRDATA, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRDATA, HRESP
   );
endinterface

// File: rtl/ahblite_acc_pid.sv
// AHB-Lite PID accelerator: incremental PID update over four cycles on one shared multiplier.
// Optional macro ACC_PID_SAT_EN: clamp the writeback to signed 32 bits instead of wrapping.
module ahblite_acc_pid (
   input  logic              HCLK,
   input  logic              HRESET,
   ahblite_acc_pid_if.slave  bus
);
   typedef enum logic [2:0] {ST_IDLE, ST_MUL_P, ST_MUL_I, ST_MUL_D, ST_WB} state_t;

   state_t             r_state;
   logic               r_dp_valid;
   logic               r_dp_write;
   logic [1:0]         r_dp_addr;
   logic signed [15:0] r_kp, r_ki, r_kd;
   logic signed [15:0] r_e, r_e1, r_e2;
   logic signed [16:0] r_d1;
   logic signed [17:0] r_d2;
   logic signed [35:0] r_acc;
   logic signed [31:0] r_u;

   logic               w_busy, w_stall, w_done;
   logic signed [15:0] w_err;
   logic signed [16:0] w_d1;
   logic signed [17:0] w_d2;
   logic signed [15:0] w_mul_a;
   logic signed [17:0] w_mul_b;
   logic signed [33:0] w_prod;
   logic signed [35:0] w_prod_ext;
   logic signed [31:0] w_fit;
   logic               w_unused;

   assign w_busy  = (r_state != ST_IDLE);
   // Writes and OUT reads wait for IDLE; CTRL/gain reads stay open for polling.
   assign w_stall = r_dp_valid && w_busy && (r_dp_write || (r_dp_addr == 2'd3));
   assign w_done  = r_dp_valid && !w_stall;

   assign w_err = bus.HWDATA[15:0];
   assign w_d1  = {w_err[15], w_err} - {r_e1[15], r_e1};
   assign w_d2  = {{2{w_err[15]}}, w_err} - {r_e1[15], r_e1, 1'b0} + {{2{r_e2[15]}}, r_e2};

   always_comb begin
      w_mul_a = '0;
      w_mul_b = '0;
      case (r_state)
         ST_MUL_P: begin w_mul_a = r_kp; w_mul_b = {r_d1[16], r_d1};         end
         ST_MUL_I: begin w_mul_a = r_ki; w_mul_b = {{2{r_e[15]}}, r_e};      end
         ST_MUL_D: begin w_mul_a = r_kd; w_mul_b = r_d2;                     end
         default:  begin w_mul_a = '0;   w_mul_b = '0;                       end
      endcase
   end

   assign w_prod     = $signed({{18{w_mul_a[15]}}, w_mul_a}) * $signed({{16{w_mul_b[17]}}, w_mul_b});
   assign w_prod_ext = {{2{w_prod[33]}}, w_prod};

`ifdef ACC_PID_SAT_EN
   always_comb begin
      if (r_acc[35:31] != {5{r_acc[35]}})
         w_fit = r_acc[35] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      else
         w_fit = r_acc[31:0];
   end
`else
   assign w_fit = r_acc[31:0];
`endif

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state    <= ST_IDLE;
         r_dp_valid <= 1'b0;
         r_dp_write <= 1'b0;
         r_dp_addr  <= '0;
         r_kp       <= '0;
         r_ki       <= '0;
         r_kd       <= '0;
         r_e        <= '0;
         r_e1       <= '0;
         r_e2       <= '0;
         r_d1       <= '0;
         r_d2       <= '0;
         r_acc      <= '0;
         r_u        <= '0;
      end else begin
         if (bus.HREADY) begin
            r_dp_valid <= bus.HSEL && bus.HTRANS[1];
            r_dp_write <= bus.HWRITE;
            r_dp_addr  <= bus.HADDR[3:2];
         end

         case (r_state)
            ST_MUL_P: begin
               r_acc   <= {{4{r_u[31]}}, r_u} + w_prod_ext;
               r_state <= ST_MUL_I;
            end
            ST_MUL_I: begin
               r_acc   <= r_acc + w_prod_ext;
               r_state <= ST_MUL_D;
            end
            ST_MUL_D: begin
               r_acc   <= r_acc + w_prod_ext;
               r_state <= ST_WB;
            end
            ST_WB: begin
               r_u     <= w_fit;
               r_e2    <= r_e1;
               r_e1    <= r_e;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase

         // Write completion only happens in IDLE, so it never collides with WB.
         if (w_done && r_dp_write) begin
            case (r_dp_addr)
               2'd0: if (bus.HWDATA[0]) begin
                  r_u  <= '0;
                  r_e1 <= '0;
                  r_e2 <= '0;
               end
               2'd1: begin
                  r_kp <= bus.HWDATA[15:0];
                  r_ki <= bus.HWDATA[31:16];
               end
               2'd2: r_kd <= bus.HWDATA[15:0];
               default: begin
                  r_e     <= w_err;
                  r_d1    <= w_d1;
                  r_d2    <= w_d2;
                  r_state <= ST_MUL_P;
               end
            endcase
         end
      end
   end

   always_comb begin
      bus.HRDATA = '0;
      if (r_dp_valid && !r_dp_write) begin
         case (r_dp_addr)
            2'd0:    bus.HRDATA = {30'd0, w_busy, 1'b0};
            2'd1:    bus.HRDATA = {r_ki, r_kp};
            2'd2:    bus.HRDATA = {16'd0, r_kd};
            default: bus.HRDATA = r_u;
         endcase
      end
   end

   assign bus.HREADYOUT = !w_stall;
   assign bus.HRESP     = 1'b0;

   assign w_unused = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], bus.HSIZE};
endmodule

// File: tb/tb_ahblite_acc_pid.sv
// Scoreboard bench for ahblite_acc_pid: a behavioural PID model predicts read data,
// pipelined AHB transfers are replayed and each completed read is compared in order.
module tb_ahblite_acc_pid;
   logic HCLK = 1'b0;
   logic HRESET;

   ahblite_acc_pid_if bus();

   ahblite_acc_pid dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   always #5 HCLK = ~HCLK;
   assign bus.HREADY = bus.HREADYOUT;

   typedef struct packed {
      logic        wr;
      logic [1:0]  idx;
      logic [31:0] wdata;
      int          waits;
   } op_t;

   op_t         op_q[$];
   string       tag_q[$];
   logic [31:0] exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state of the accelerator.
   int m_u, m_e1, m_e2, m_kp, m_ki, m_kd;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic int fit(input longint v);
`ifdef ACC_PID_SAT_EN
      if (v > 64'sd2147483647)  return 32'sh7FFF_FFFF;
      if (v < -64'sd2147483648) return 32'sh8000_0000;
`endif
      return int'(v);
   endfunction

   task automatic model_reset();
      m_u = 0; m_e1 = 0; m_e2 = 0; m_kp = 0; m_ki = 0; m_kd = 0;
   endtask

   task automatic push_wr(input logic [1:0] idx, input logic [31:0] d, input int waits, input string tag);
      op_t    o;
      int     e;
      longint v;
      o.wr = 1'b1; o.idx = idx; o.wdata = d; o.waits = waits;
      op_q.push_back(o);
      tag_q.push_back(tag);
      case (idx)
         2'd0: if (d[0]) begin m_u = 0; m_e1 = 0; m_e2 = 0; end
         2'd1: begin m_kp = int'($signed(d[15:0])); m_ki = int'($signed(d[31:16])); end
         2'd2: m_kd = int'($signed(d[15:0]));
         default: begin
            e = int'($signed(d[15:0]));
            v = longint'(m_u) + longint'(m_kp) * (e - m_e1) + longint'(m_ki) * e
              + longint'(m_kd) * (e - 2 * m_e1 + m_e2);
            m_u  = fit(v);
            m_e2 = m_e1;
            m_e1 = e;
         end
      endcase
   endtask

   task automatic push_rd(input logic [1:0] idx, input logic busy, input int waits, input string tag);
      op_t         o;
      logic [31:0] kp, ki, kd;
      o.wr = 1'b0; o.idx = idx; o.wdata = '0; o.waits = waits;
      op_q.push_back(o);
      tag_q.push_back(tag);
      kp = m_kp; ki = m_ki; kd = m_kd;
      case (idx)
         2'd0:    exp_q.push_back({30'd0, busy, 1'b0});
         2'd1:    exp_q.push_back({ki[15:0], kp[15:0]});
         2'd2:    exp_q.push_back({16'd0, kd[15:0]});
         default: exp_q.push_back(m_u);
      endcase
   endtask

   task automatic bus_idle();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'b0;
      bus.HADDR  = 32'h0;
      bus.HWDATA = 32'h0;
   endtask

   // Back-to-back pipelined transfers; returns one tick after the last data phase completes.
   task automatic run_ops();
      op_t   dp;
      logic  have_dp = 1'b0;
      logic  rdy;
      int    waits = 0;
      string dtag = "";
      dp = '0;
      while (op_q.size() > 0 || have_dp) begin
         if (op_q.size() > 0) begin
            bus.HSEL   = 1'b1;
            bus.HTRANS = 2'b10;
            bus.HWRITE = op_q[0].wr;
            bus.HADDR  = 32'h4000_0010 | {28'd0, op_q[0].idx, 2'b00};
         end else begin
            bus.HSEL   = 1'b0;
            bus.HTRANS = 2'b00;
            bus.HWRITE = 1'b0;
         end
         bus.HWDATA = (have_dp && dp.wr) ? dp.wdata : 32'h0;
         @(negedge HCLK);
         rdy = bus.HREADYOUT;
         if (have_dp && rdy) begin
            if (!dp.wr) check_eq({dtag, "/rdata"}, bus.HRDATA, exp_q.pop_front());
            if (dp.waits >= 0) check_eq({dtag, "/waits"}, waits, dp.waits);
            check_eq({dtag, "/hresp"}, {31'd0, bus.HRESP}, 32'd0);
         end
         @(posedge HCLK);
         #1;
         if (rdy) begin
            have_dp = 1'b0;
            if (op_q.size() > 0) begin
               dp      = op_q.pop_front();
               dtag    = tag_q.pop_front();
               have_dp = 1'b1;
               waits   = 0;
            end
         end else begin
            waits++;
            if (waits > 32) begin
               check_eq({dtag, "/timeout"}, waits, 32'd0);
               op_q.delete(); tag_q.delete(); exp_q.delete();
               have_dp = 1'b0;
            end
         end
      end
      bus_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESET     = 1'b1;
      bus.HSIZE  = 3'b010;
      bus_idle();
      model_reset();
      repeat (3) @(posedge HCLK);
      #1;
      HRESET = 1'b0;

      // Reset state
      push_rd(2'd0, 1'b0, 0, "rst_ctrl");
      push_rd(2'd1, 1'b0, 0, "rst_gain0");
      push_rd(2'd2, 1'b0, 0, "rst_gain1");
      push_rd(2'd3, 1'b0, 0, "rst_out");
      run_ops();

      // Incremental P and I
      push_wr(2'd1, 32'h0001_0002, 0, "pi_gain0");
      push_wr(2'd3, 32'd10, 0, "pi_err1");
      push_rd(2'd3, 1'b0, 4, "pi_out1");
      run_ops();
      push_wr(2'd3, 32'd10, 0, "pi_err2");
      push_rd(2'd3, 1'b0, 4, "pi_out2");
      push_rd(2'd1, 1'b0, 0, "pi_gain0_rb");
      run_ops();

      // D term from cleared history
      push_wr(2'd0, 32'd1, 0, "d_clr");
      push_wr(2'd1, 32'd0, 0, "d_gain0");
      push_wr(2'd2, 32'd3, 0, "d_kd");
      push_rd(2'd2, 1'b0, 0, "d_gain1_rb");
      run_ops();
      for (int i = 0; i < 3; i++) begin
         push_wr(2'd3, (i == 2) ? 32'd0 : 32'd5, 0, "d_err");
         push_rd(2'd3, 1'b0, 4, "d_out");
         run_ops();
      end

      // BUSY poll, then a write issued mid-computation
      push_wr(2'd3, 32'hFFFF_FFF9, 0, "poll_err");
      for (int i = 0; i < 4; i++) push_rd(2'd0, 1'b1, 0, "poll_busy");
      push_rd(2'd0, 1'b0, 0, "poll_idle");
      push_rd(2'd3, 1'b0, 0, "poll_out");
      run_ops();
      push_wr(2'd3, 32'd2, 0, "stall_err");
      push_wr(2'd2, 32'd7, 4, "stall_kd");
      push_rd(2'd2, 1'b0, 0, "stall_kd_rb");
      push_rd(2'd3, 1'b0, 0, "stall_out");
      run_ops();

      // Saturation / wrap
      push_wr(2'd0, 32'd1, 0, "sat_clr");
      push_wr(2'd1, 32'h7FFF_0000, 0, "sat_gain0");
      push_wr(2'd2, 32'd0, 0, "sat_gain1");
      run_ops();
      for (int i = 0; i < 3; i++) begin
         push_wr(2'd3, 32'h0000_7FFF, 0, "sat_err");
         push_rd(2'd3, 1'b0, 4, "sat_out");
         run_ops();
      end

      // CLR pipelined behind ERR
      push_wr(2'd1, 32'h0002_0003, 0, "clr_gain0");
      push_wr(2'd3, 32'd100, 0, "clr_err");
      push_wr(2'd0, 32'd1, 4, "clr_stall");
      push_rd(2'd3, 1'b0, 0, "clr_out");
      run_ops();

      // Reset in MUL_I
      push_wr(2'd2, 32'd5, 0, "rstm_kd");
      push_wr(2'd3, 32'd20, 0, "rstm_err1");
      push_rd(2'd3, 1'b0, 4, "rstm_out_pre");
      run_ops();
      push_wr(2'd3, 32'd50, 0, "rstm_err2");
      run_ops();
      @(posedge HCLK);
      #1;
      HRESET = 1'b1;
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      model_reset();
      push_rd(2'd0, 1'b0, 0, "rstm_ctrl");
      push_rd(2'd3, 1'b0, 0, "rstm_out");
      push_rd(2'd1, 1'b0, 0, "rstm_gain0");
      push_rd(2'd2, 1'b0, 0, "rstm_gain1");
      run_ops();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
